hdp_spi_responder: RTL

//  SPI responder (slave) for the HDP-1280-2 register protocol: CPOL=0, CPHA=0, 16-bit frames, MSB first.

---
 rtl/hdp_spi_responder_if.sv | 14 +
 rtl/hdp_spi_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hdp_spi_responder_if.sv
// SPI pin bundle between an HDP SPI master and the register responder.
// Latency: none (wires only).
// Backpressure: none; SPI has no flow control, the master owns SCLK/CS timing.
// Signals: SCLK, CS (active low), MOSI driven by master; MISO, miso_oe driven by responder.
interface hdp_spi_responder_if;
    logic SCLK;
    logic CS;
    logic MOSI;
    logic MISO;
    logic miso_oe;

    modport master (output SCLK, output CS, output MOSI, input MISO, input miso_oe);
    modport slave  (input SCLK, input CS, input MOSI, output MISO, output miso_oe);
endinterface

// File: rtl/hdp_spi_responder.sv
// SPI mode-0 register responder: 16-bit frames {RW, addr[6:0], data[7:0]}, MSB first, 8-bit register file.
// Latency: SPI pin edge to internal action is SYNC_STAGES+1 i_clock cycles; commit on synchronised CS rise.
// Backpressure: none; fabric writes always accepted (SPI write wins on same-address collision).
// Ports: i_clock/i_reset (async, active high); spi (slave modport: SCLK, CS, MOSI, MISO, miso_oe);
//        i_fab_we/i_fab_addr/i_fab_data fabric write port; o_busy; o_wr_strobe/o_rd_strobe/o_frame_err
//        one-cycle pulses; o_addr/o_wr_data last committed frame; o_regs flattened register file.
module hdp_spi_responder #(
    parameter int WORD_WIDTH  = 8,
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    hdp_spi_responder_if.slave             spi,
    input  logic                           i_fab_we,
    input  logic [6:0]                     i_fab_addr,
    input  logic [WORD_WIDTH-1:0]          i_fab_data,
    output logic                           o_busy,
    output logic                           o_wr_strobe,
    output logic                           o_rd_strobe,
    output logic [6:0]                     o_addr,
    output logic [WORD_WIDTH-1:0]          o_wr_data,
    output logic                           o_frame_err,
    output logic [WORD_WIDTH*NUM_REGS-1:0] o_regs
);
    localparam int         IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [4:0] CNT_HDR_M1 = 5'(WORD_WIDTH - 1);
    localparam logic [4:0] CNT_HDR    = 5'(WORD_WIDTH);
    localparam logic [4:0] CNT_FRM    = 5'(2 * WORD_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    function automatic logic in_range(input logic [6:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, active, commit;
    state_t                 state_q, state_d;
    logic [4:0]             cnt_q;
    logic [WORD_WIDTH-1:0]  rx_q, tx_q, hdr;
    logic                   miso_q, rw_q;
    logic [6:0]             addr_q, hdr_addr;
    logic [WORD_WIDTH-1:0]  regs_q [NUM_REGS];
    logic                   spi_we, fab_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    // SCLK is only honoured inside a frame we saw start; this also drops a frame
    // that was already running when reset released.
    assign active    = (state_q != S_IDLE) && !cs_s;
    // A CS rise while IDLE has no frame behind it (e.g. right after reset) and is ignored.
    assign commit    = cs_rise && (state_q != S_IDLE);

    // Header byte as it will stand after the current rising edge.
    assign hdr      = {rx_q[WORD_WIDTH-2:0], mosi_s};
    assign hdr_addr = hdr[6:0];

    assign spi_we = commit && (cnt_q == CNT_FRM) && !rw_q && in_range(addr_q);
    assign fab_ok = i_fab_we && in_range(i_fab_addr);

    assign spi.MISO    = miso_q;
    assign spi.miso_oe = (state_q != S_IDLE);
    assign o_busy      = (state_q != S_IDLE);

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
        assign o_regs[n*WORD_WIDTH +: WORD_WIDTH] = regs_q[n];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cs_fall) state_d = S_ADDR;
            S_ADDR: if (active && sclk_rise && cnt_q == CNT_HDR_M1) state_d = S_DATA;
            S_DATA: if (active && sclk_rise && cnt_q == CNT_FRM - 5'd1) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (commit) state_d = S_IDLE;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            o_wr_strobe <= 1'b0;
            o_rd_strobe <= 1'b0;
            o_frame_err <= 1'b0;
            o_addr      <= '0;
            o_wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            sclk_sync_q[0] <= spi.SCLK;
            cs_sync_q[0]   <= spi.CS;
            mosi_sync_q[0] <= spi.MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;

            o_wr_strobe <= 1'b0;
            o_rd_strobe <= 1'b0;
            o_frame_err <= 1'b0;

            if (cs_fall || cs_rise) begin
                cnt_q  <= '0;
                rx_q   <= '0;
                tx_q   <= '0;
                miso_q <= 1'b0;
            end else if (active) begin
                if (sclk_rise) begin
                    rx_q  <= hdr;
                    cnt_q <= (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                    if (cnt_q == CNT_HDR_M1) begin
                        rw_q   <= hdr[WORD_WIDTH-1];
                        addr_q <= hdr_addr;
                        // Snapshot: later fabric writes cannot disturb the bits in flight.
                        tx_q   <= (hdr[WORD_WIDTH-1] && in_range(hdr_addr))
                                  ? regs_q[hdr_addr[IW-1:0]] : '0;
                    end
                end
                if (sclk_fall) begin
                    // Falls 8..15 present the read byte so the master samples it on rises 9..16.
                    if (cnt_q >= CNT_HDR && cnt_q < CNT_FRM) begin
                        miso_q <= tx_q[WORD_WIDTH-1];
                        tx_q   <= {tx_q[WORD_WIDTH-2:0], 1'b0};
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
            end

            if (commit) begin
                if (cnt_q == CNT_FRM) begin
                    o_addr <= addr_q;
                    if (rw_q) begin
                        o_rd_strobe <= 1'b1;
                    end else begin
                        o_wr_data   <= rx_q;
                        o_wr_strobe <= 1'b1;
                    end
                end else begin
                    o_frame_err <= 1'b1;
                end
            end

            // SPI write is ordered last so it wins a same-address collision.
            if (fab_ok) regs_q[i_fab_addr[IW-1:0]] <= i_fab_data;
            if (spi_we) regs_q[addr_q[IW-1:0]]     <= rx_q;
        end
    end
endmodule
